// File: rtl/batch_filter_array.sv
// batch_filter_array
// N-channel control-bounded filter core. Each control bit drives its own
// complex one-pole recursion w = F*w +/- L (fixed point, saturating); the
// real parts of all channels are summed, saturated and decimated into a
// single output stream with a sticky overflow flag.
//
// Pipeline: stage 1 updates the channel state on the accepting edge, stage 2
// registers the saturated sum of that updated state on the following edge.

module batch_filter_array #(
    parameter int                 N     = 3,
    parameter int                 width = 32,
    parameter int                 frac  = 16,
    parameter int                 decim = 1,
    parameter logic [N*width-1:0] FR    = {N{32'h0000_8000}},
    parameter logic [N*width-1:0] FI    = {N{32'h0000_0000}},
    parameter logic [N*width-1:0] LR    = {N{32'h0001_0000}},
    parameter logic [N*width-1:0] LI    = {N{32'h0000_0000}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [N-1:0]     in,
    input  logic             in_valid,
    output logic [width-1:0] out,
    output logic             out_valid,
    output logic             ovf
);

    // One full width x width product.
    localparam int PROD_W = 2 * width;
    // Complex product difference/sum (2*width+1) plus headroom for the +/-L add.
    localparam int ACC_W  = 2 * width + 2;
    // Channel sum before saturation.
    localparam int SUM_W  = width + $clog2(N);
    // Decimation counter covers decim up to 65535.
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(decim - 1);

    localparam logic [width-1:0] SAT_MAX = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0] SAT_MIN = {1'b1, {(width-1){1'b0}}};

    // ------------------------------------------------------------------
    // Fixed-point helpers
    // ------------------------------------------------------------------
    function automatic logic signed [PROD_W-1:0] ext_prod(input logic [width-1:0] v);
        return PROD_W'(signed'(v));
    endfunction

    function automatic logic signed [ACC_W-1:0] ext_acc(input logic [width-1:0] v);
        return ACC_W'(signed'(v));
    endfunction

    function automatic logic signed [ACC_W-1:0] prod_to_acc(input logic [PROD_W-1:0] v);
        return ACC_W'(signed'(v));
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_sum(input logic [width-1:0] v);
        return SUM_W'(signed'(v));
    endfunction

    // A value fits in width bits when every bit above the target sign bit
    // equals that sign bit.
    function automatic logic fits_acc(input logic [ACC_W-1:0] v);
        logic [ACC_W-width:0] top;
        top = v[ACC_W-1:width-1];
        return (&top) | ~(|top);
    endfunction

    function automatic logic [width-1:0] sat_acc(input logic [ACC_W-1:0] v);
        if (fits_acc(v)) begin
            return v[width-1:0];
        end
        return v[ACC_W-1] ? SAT_MIN : SAT_MAX;
    endfunction

    function automatic logic fits_sum(input logic [SUM_W-1:0] v);
        logic [SUM_W-width:0] top;
        top = v[SUM_W-1:width-1];
        return (&top) | ~(|top);
    endfunction

    function automatic logic [width-1:0] sat_sum(input logic [SUM_W-1:0] v);
        if (fits_sum(v)) begin
            return v[width-1:0];
        end
        return v[SUM_W-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [width-1:0] wr_q [N];
    logic [width-1:0] wi_q [N];
    logic [width-1:0] wr_d [N];
    logic [width-1:0] wi_d [N];

    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             emit_q,      emit_d;       // stage-2 result in flight
    logic [width-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q,       ovf_d;

    logic             accept;
    logic [N-1:0]     clip_s1;
    logic [SUM_W-1:0] sum_full;
    logic [width-1:0] sum_sat;
    logic             clip_s2;

    // clear wins over in_valid: a sample presented together with clear is dropped.
    assign accept = in_valid & ~clear;

    // Stage 1: next complex state of every channel and its clip flags.
    always_comb begin
        logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
        logic signed [ACC_W-1:0]  acc_r, acc_i;
        logic signed [ACC_W-1:0]  l_r, l_i;
        // NOTE: every variable written here gets a default before any branch, so no latch can be inferred.
        p_rr    = '0;
        p_ii    = '0;
        p_ri    = '0;
        p_ir    = '0;
        acc_r   = '0;
        acc_i   = '0;
        l_r     = '0;
        l_i     = '0;
        clip_s1 = '0;
        for (int c = 0; c < N; c++) begin
            wr_d[c] = wr_q[c];
            wi_d[c] = wi_q[c];
        end

        for (int c = 0; c < N; c++) begin
            p_rr  = ext_prod(wr_q[c]) * ext_prod(FR[c*width +: width]);
            p_ii  = ext_prod(wi_q[c]) * ext_prod(FI[c*width +: width]);
            p_ri  = ext_prod(wr_q[c]) * ext_prod(FI[c*width +: width]);
            p_ir  = ext_prod(wi_q[c]) * ext_prod(FR[c*width +: width]);

            // Arithmetic shift of the signed product sum: rounds toward -inf.
            acc_r = (prod_to_acc(p_rr) - prod_to_acc(p_ii)) >>> frac;
            acc_i = (prod_to_acc(p_ri) + prod_to_acc(p_ir)) >>> frac;

            l_r   = ext_acc(LR[c*width +: width]);
            l_i   = ext_acc(LI[c*width +: width]);
            acc_r = in[c] ? acc_r + l_r : acc_r - l_r;
            acc_i = in[c] ? acc_i + l_i : acc_i - l_i;

            clip_s1[c] = ~fits_acc(acc_r) | ~fits_acc(acc_i);

            if (clear) begin
                wr_d[c] = '0;
                wi_d[c] = '0;
            end else if (accept) begin
                wr_d[c] = sat_acc(acc_r);
                wi_d[c] = sat_acc(acc_i);
            end
        end
    end

    // Stage 2: saturated sum of the channel real parts held in state.
    always_comb begin
        sum_full = '0;
        for (int c = 0; c < N; c++) begin
            sum_full = sum_full + ext_sum(wr_q[c]);
        end
        sum_sat = sat_sum(sum_full);
        clip_s2 = ~fits_sum(sum_full);
    end

    // Decimation, output register and sticky overflow next-state.
    always_comb begin
        cnt_d       = cnt_q;
        emit_d      = 1'b0;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;

        if (clear) begin
            cnt_d = '0;
            out_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (accept) begin
                emit_d = (cnt_q == CNT_LAST);
                cnt_d  = emit_d ? '0 : cnt_q + CNT_W'(1);
                if (|clip_s1) begin
                    ovf_d = 1'b1;
                end
            end
            // The stage-1 state registered on the previous edge is summed now.
            if (emit_q) begin
                out_d       = sum_sat;
                out_valid_d = 1'b1;
                if (clip_s2) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the channel state array is reset as well: a zero recursion state after reset is part of the block's behaviour.
            for (int c = 0; c < N; c++) begin
                wr_q[c] <= '0;
                wi_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                wr_q[c] <= wr_d[c];
                wi_q[c] <= wi_d[c];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q       <= '0;
            emit_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            emit_q      <= emit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_batch_filter_array.sv
// Bench for batch_filter_array: three instances (default coefficients,
// a saturating configuration, and a decimating complex configuration) share
// one stimulus stream. An integer reference model predicts, per output cycle,
// out/out_valid/ovf for every instance; a single compare process checks all
// instances each cycle, and directed literal checks pin the model.

module tb_batch_filter_array;

    localparam int NI    = 3;   // instances
    localparam int NCH   = 3;   // channels per instance
    localparam int FRAC  = 16;
    localparam int NEVER = 32'h7FFF_FFFF;

    localparam logic [95:0] ZERO96 = 96'h0;
    localparam logic [95:0] SAT_FR = {3{32'h0001_0000}};
    localparam logic [95:0] SAT_LR = {3{32'h4000_0000}};
    localparam logic [95:0] DEC_FR = {32'h0000_6000, 32'hFFFF_4000, 32'h0000_C000};
    localparam logic [95:0] DEC_FI = {32'hFFFF_C000, 32'h0000_2000, 32'h0000_4000};
    localparam logic [95:0] DEC_LR = {32'h0000_8000, 32'h0001_0000, 32'h0000_C000};
    localparam logic [95:0] DEC_LI = {32'h0000_4000, 32'hFFFF_8000, 32'h0000_2000};
    localparam logic [95:0] DEF_FR = {3{32'h0000_8000}};
    localparam logic [95:0] DEF_LR = {3{32'h0001_0000}};

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [2:0]  in_b;
    logic        in_valid;
    logic [31:0] out_w       [NI];
    logic        out_valid_w [NI];
    logic        ovf_w       [NI];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    batch_filter_array u_def (
        .clk(clk), .rst(rst), .clear(clear), .in(in_b), .in_valid(in_valid),
        .out(out_w[0]), .out_valid(out_valid_w[0]), .ovf(ovf_w[0])
    );

    batch_filter_array #(.FR(SAT_FR), .FI(ZERO96), .LR(SAT_LR), .LI(ZERO96)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .in(in_b), .in_valid(in_valid),
        .out(out_w[1]), .out_valid(out_valid_w[1]), .ovf(ovf_w[1])
    );

    batch_filter_array #(.decim(4), .FR(DEC_FR), .FI(DEC_FI), .LR(DEC_LR), .LI(DEC_LI)) u_dec (
        .clk(clk), .rst(rst), .clear(clear), .in(in_b), .in_valid(in_valid),
        .out(out_w[2]), .out_valid(out_valid_w[2]), .ovf(ovf_w[2])
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t         evq [$];           // expected output pulses, by edge number
    int          fr_m [NI][NCH];
    int          fi_m [NI][NCH];
    int          lr_m [NI][NCH];
    int          li_m [NI][NCH];
    int          decim_m [NI];
    int          wr_m [NI][NCH];
    int          wi_m [NI][NCH];
    int          cnt_m [NI];
    int          ovf_from [NI];     // first edge at which ovf must read 1
    logic [31:0] last_out [NI];

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d at edge %0d: got %h expected %h", name, inst, cyc, got, exp);
        end
    endtask

    function automatic logic signed [127:0] s128(input int v);
        return {{96{v[31]}}, v};
    endfunction

    function automatic logic signed [127:0] clamp32(input logic signed [127:0] x, output logic clipped);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = s128(32'h7FFF_FFFF);
        lo = s128(32'h8000_0000);
        clipped = 1'b0;
        if (x > hi) begin
            clipped = 1'b1;
            return hi;
        end
        if (x < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return x;
    endfunction

    task automatic unpack_params(input int i, input logic [95:0] fr, input logic [95:0] fi,
                                 input logic [95:0] lr, input logic [95:0] li, input int dm);
        for (int c = 0; c < NCH; c++) begin
            fr_m[i][c] = fr[c*32 +: 32];
            fi_m[i][c] = fi[c*32 +: 32];
            lr_m[i][c] = lr[c*32 +: 32];
            li_m[i][c] = li[c*32 +: 32];
        end
        decim_m[i] = dm;
    endtask

    task automatic zero_state();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NCH; c++) begin
                wr_m[i][c] = 0;
                wi_m[i][c] = 0;
            end
            cnt_m[i]    = 0;
            ovf_from[i] = NEVER;
            last_out[i] = 32'h0;
        end
    endtask

    task automatic model_reset();
        evq.delete();
        zero_state();
    endtask

    // clear at edge p: nothing scheduled for edge p or later survives.
    task automatic model_clear(input int p);
        for (int k = evq.size() - 1; k >= 0; k--) begin
            if (evq[k].cyc >= p) evq.delete(k);
        end
        zero_state();
    endtask

    // Sample accepted at edge p: new state at p, summed output at p+1.
    task automatic model_accept(input logic [2:0] bits, input int p);
        for (int i = 0; i < NI; i++) begin
            logic signed [127:0] xr, xi, s, sv;
            logic clp;
            s = 0;
            for (int c = 0; c < NCH; c++) begin
                xr = (s128(wr_m[i][c]) * s128(fr_m[i][c]) - s128(wi_m[i][c]) * s128(fi_m[i][c])) >>> FRAC;
                xi = (s128(wr_m[i][c]) * s128(fi_m[i][c]) + s128(wi_m[i][c]) * s128(fr_m[i][c])) >>> FRAC;
                xr = bits[c] ? xr + s128(lr_m[i][c]) : xr - s128(lr_m[i][c]);
                xi = bits[c] ? xi + s128(li_m[i][c]) : xi - s128(li_m[i][c]);
                xr = clamp32(xr, clp);
                if (clp && p < ovf_from[i]) ovf_from[i] = p;
                xi = clamp32(xi, clp);
                if (clp && p < ovf_from[i]) ovf_from[i] = p;
                wr_m[i][c] = xr[31:0];
                wi_m[i][c] = xi[31:0];
                s = s + s128(wr_m[i][c]);
            end
            cnt_m[i]++;
            if (cnt_m[i] == decim_m[i]) begin
                cnt_m[i] = 0;
                sv = clamp32(s, clp);
                if (clp && (p + 1) < ovf_from[i]) ovf_from[i] = p + 1;
                evq.push_back('{inst: i, cyc: p + 1, val: sv[31:0]});
            end
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge), update the
    // model for the coming rising edge, then return just after the next falling edge.
    task automatic step(input logic [2:0] b, input logic v, input logic c);
        in_b     = b;
        in_valid = v;
        clear    = c;
        if (!rst) begin
            if (c) model_clear(cyc + 1);
            else if (v) model_accept(b, cyc + 1);
        end
        @(negedge clk);
        #1;
    endtask

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        logic        hit;
        logic [31:0] ev_val;
        for (int i = 0; i < NI; i++) begin
            hit    = 1'b0;
            ev_val = 32'h0;
            for (int k = 0; k < evq.size(); k++) begin
                if (evq[k].inst == i && evq[k].cyc == cyc) begin
                    hit    = 1'b1;
                    ev_val = evq[k].val;
                end
            end
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].inst == i && evq[k].cyc <= cyc) evq.delete(k);
            end
            if (hit) last_out[i] = ev_val;
            check("out_valid", i, {31'b0, out_valid_w[i]}, {31'b0, hit});
            check("out", i, out_w[i], last_out[i]);
            check("ovf", i, {31'b0, ovf_w[i]}, {31'b0, (cyc >= ovf_from[i])});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] cont_exp [5];
    int          pulses;
    int          acc, prev, np;
    int          pos [2];

    task automatic note_dec_pulse(input int src);
        if (out_valid_w[2]) begin
            if (np < 2) pos[np] = src;
            np++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_b     = 3'b000;
        in_valid = 1'b0;
        unpack_params(0, DEF_FR, ZERO96, DEF_LR, ZERO96, 1);
        unpack_params(1, SAT_FR, ZERO96, SAT_LR, ZERO96, 1);
        unpack_params(2, DEC_FR, DEC_FI, DEC_LR, DEC_LI, 4);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Single sample: result two cycles after presentation, then held.
        step(3'b111, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        check("single_out", 0, out_w[0], 32'h0003_0000);
        check("single_valid", 0, {31'b0, out_valid_w[0]}, 32'h1);
        step(3'b000, 1'b0, 1'b0);
        check("single_hold", 0, out_w[0], 32'h0003_0000);
        check("single_pulse_end", 0, {31'b0, out_valid_w[0]}, 32'h0);

        // Asynchronous reset mid-cycle with a result in flight.
        step(3'b111, 1'b1, 1'b0);
        in_b     = 3'b000;
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_out", i, out_w[i], 32'h0);
            check("rst_valid", i, {31'b0, out_valid_w[i]}, 32'h0);
            check("rst_ovf", i, {31'b0, ovf_w[i]}, 32'h0);
        end
        step(3'b000, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            step(3'b000, 1'b0, 1'b0);
            if (out_valid_w[0] || out_valid_w[1] || out_valid_w[2]) pulses++;
        end
        check("post_reset_pulses", 0, pulses, 0);

        // Continuous 111 then one 000.
        cont_exp[0] = 32'h0003_0000;
        cont_exp[1] = 32'h0004_8000;
        cont_exp[2] = 32'h0005_4000;
        cont_exp[3] = 32'h0005_A000;
        cont_exp[4] = 32'hFFFF_D000;
        for (int i = 0; i < 6; i++) begin
            step((i < 4) ? 3'b111 : 3'b000, (i < 5), 1'b0);
            if (i >= 1) begin
                check("cont_out", 0, out_w[0], cont_exp[i-1]);
                check("cont_valid", 0, {31'b0, out_valid_w[0]}, 32'h1);
            end
        end

        // Mixed bits and clear colliding with a valid sample.
        step(3'b000, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        check("mix_out", 0, out_w[0], 32'h0001_0000);
        step(3'b101, 1'b1, 1'b1);
        step(3'b000, 1'b0, 1'b0);
        check("clear_out", 0, out_w[0], 32'h0);
        check("clear_valid", 0, {31'b0, out_valid_w[0]}, 32'h0);
        step(3'b101, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        check("mix_again_out", 0, out_w[0], 32'h0001_0000);

        // Saturation on the FR=1.0, LR=0x4000_0000 instance.
        step(3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(3'b111, (i < 4), 1'b0);
            if (i >= 1) begin
                check("sat_out", 1, out_w[1], 32'h7FFF_FFFF);
                check("sat_ovf", 1, {31'b0, ovf_w[1]}, 32'h1);
            end
        end
        step(3'b000, 1'b0, 1'b0);
        check("sat_ovf_sticky", 1, {31'b0, ovf_w[1]}, 32'h1);
        step(3'b000, 1'b0, 1'b1);
        check("sat_ovf_cleared", 1, {31'b0, ovf_w[1]}, 32'h0);
        check("sat_out_cleared", 1, out_w[1], 32'h0);

        // Decimation by 4: 10 accepted samples with random single-cycle gaps.
        acc = 0;
        np  = 0;
        pos[0] = -1;
        pos[1] = -1;
        while (acc < 10) begin
            prev = acc;
            step(3'($urandom_range(0, 7)), 1'b1, 1'b0);
            acc++;
            note_dec_pulse(prev);
            if ($urandom_range(0, 1) == 1) begin
                prev = acc;
                step(3'b000, 1'b0, 1'b0);
                note_dec_pulse(prev);
            end
        end
        repeat (2) begin
            prev = acc;
            step(3'b000, 1'b0, 1'b0);
            note_dec_pulse(prev);
        end
        check("dec_pulses", 2, np, 2);
        check("dec_first_at", 2, pos[0], 4);
        check("dec_second_at", 2, pos[1], 8);

        // Random soak with occasional clears.
        step(3'b000, 1'b0, 1'b1);
        repeat (400) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset drops a set overflow flag immediately.
        step(3'b000, 1'b0, 1'b1);
        repeat (3) step(3'b111, 1'b1, 1'b0);
        check("pre_rst_ovf", 1, {31'b0, ovf_w[1]}, 32'h1);
        in_b     = 3'b000;
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst2_ovf", 1, {31'b0, ovf_w[1]}, 32'h0);
        check("rst2_out", 1, out_w[1], 32'h0);
        check("rst2_valid", 1, {31'b0, out_valid_w[1]}, 32'h0);
        step(3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) step(3'b000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
